// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the WM8731 audio path (audio_rx and audio_tx).
// Holds the ws channel encoding, the audio word width presented to the
// system, the bit-counter width and the receive state enumeration.
// No ports; imported with "import audio_pkg::*;".

package audio_pkg;

   // ws (lrclk) level that selects each channel on the codec pins
   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   // Width of the sign-extended words handed to the system
   localparam int AUDIO_WORD_W = 32;

   // Width of the per-word bit counter
   localparam int BITCNT_W = 6;

   // Receive states: HUNT discards until the first channel boundary
   typedef enum logic [1:0] {
      HUNT,
      LEFT,
      RIGHT
   } rxState_e;

   // Saturating increment for the bit counter, so it sticks at all-ones
   function automatic logic [BITCNT_W-1:0] satInc(input logic [BITCNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Synchroniser for the asynchronous codec inputs. One edge input (bclk)
// and a bundle of data inputs (ws, sdata) travel through identical
// STAGES-deep flop chains so they stay mutually aligned; a rising-edge
// detector is applied to the edge input only.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   edge_i  in   asynchronous clock-like input (bclk)
//   data_i  in   WIDTH asynchronous inputs sampled alongside edge_i
//   data_o  out  synchronised data_i
//   rise_o  out  1 when synchronised edge_i is 1 and was 0 one cycle earlier

module sync_edge #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             edge_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             rise_o
);

   // The edge bit rides in bit 0 of a common chain so every input sees
   // exactly the same number of flops.
   logic [WIDTH:0] chain_q [STAGES];
   logic           edgePrev_q;

   // Shift the combined chain one stage per clock and remember the last
   // synchronised edge value so a 0->1 step can be detected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
         edgePrev_q <= 1'b0;
      end else begin
         chain_q[0] <= {data_i, edge_i};
         for (int i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
         edgePrev_q <= chain_q[STAGES-1][0];
      end
   end

   assign data_o = chain_q[STAGES-1][WIDTH:1];
   assign rise_o = chain_q[STAGES-1][0] & ~edgePrev_q;

endmodule

// File: rtl/audio_rx.sv
// audio_rx
// I2S receive engine for the WM8731 ADC path. Oversamples bclk, adclrc
// and adcdat in the clk domain, deserialises one left and one right word
// per frame and presents the pair with a one-cycle valid strobe.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   sck_bclk    in   codec bit clock (asynchronous)
//   ws_lrc      in   adclrc, 0 = left, 1 = right
//   sdata       in   adcdat, MSB first
//   left_data   out  last complete left word, sign-extended
//   right_data  out  last complete right word, sign-extended
//   data_valid  out  one-cycle pulse when a new pair is presented
//   short_word  out  one-cycle pulse when a word closed with too few bits

module audio_rx
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sck_bclk,
   input  logic                    ws_lrc,
   input  logic                    sdata,
   output logic [AUDIO_WORD_W-1:0] left_data,
   output logic [AUDIO_WORD_W-1:0] right_data,
   output logic                    data_valid,
   output logic                    short_word
);

   localparam logic [BITCNT_W-1:0] FULL_CNT = BITCNT_W'(DATA_WIDTH);

   logic [1:0]              syncData;
   logic                    wsSync;
   logic                    sdSync;
   logic                    bclkRise;

   rxState_e                state_q;
   logic [BITCNT_W-1:0]     bitCnt_q;
   logic [DATA_WIDTH-1:0]   shreg_q;
   logic                    ws_q;
   logic                    haveLeft_q;
   logic [AUDIO_WORD_W-1:0] hold_q;
   logic [AUDIO_WORD_W-1:0] left_q;
   logic [AUDIO_WORD_W-1:0] right_q;
   logic                    valid_q;
   logic                    short_q;

   logic                    boundary;
   logic                    roomLeft;
   logic [DATA_WIDTH-1:0]   shreg_d;
   logic [BITCNT_W-1:0]     bitCnt_d;
   logic                    isShort;
   logic [DATA_WIDTH-1:0]   closedWord;
   logic [AUDIO_WORD_W-1:0] closedWide;
   logic [AUDIO_WORD_W-1:0] closedExt;

   sync_edge #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (2)
   ) uSync (
      .clk    (clk),
      .rst_n  (rst_n),
      .edge_i (sck_bclk),
      .data_i ({sdata, ws_lrc}),
      .data_o (syncData),
      .rise_o (bclkRise)
   );

   assign wsSync = syncData[0];
   assign sdSync = syncData[1];

   // Datapath for one bclk rise. The bit on a rise always belongs to the
   // word being built (on a boundary it is the old word's LSB slot), so
   // the shifted register and count are shared by capture and close.
   // Closing left-justifies a short word by the missing bit count, then
   // sign-extends from DATA_WIDTH-1 using an arithmetic shift pair.
   always_comb begin
      boundary   = bclkRise && (wsSync != ws_q);
      roomLeft   = bitCnt_q < FULL_CNT;
      shreg_d    = roomLeft ? DATA_WIDTH'({shreg_q, sdSync}) : shreg_q;
      bitCnt_d   = roomLeft ? satInc(bitCnt_q) : bitCnt_q;
      isShort    = bitCnt_d < FULL_CNT;
      closedWord = shreg_d << (FULL_CNT - bitCnt_d);
      closedWide = AUDIO_WORD_W'(closedWord) << (AUDIO_WORD_W - DATA_WIDTH);
      closedExt  = AUDIO_WORD_W'($signed(closedWide) >>> (AUDIO_WORD_W - DATA_WIDTH));
   end

   // Receive state machine with registered outputs. HUNT throws away the
   // partial word seen after reset. A right word closed without a
   // preceding left word (haveLeft_q clear) produces no valid strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         bitCnt_q   <= '0;
         shreg_q    <= '0;
         ws_q       <= WS_LEFT;
         haveLeft_q <= 1'b0;
         hold_q     <= '0;
         left_q     <= '0;
         right_q    <= '0;
         valid_q    <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         short_q <= 1'b0;
         if (bclkRise) begin
            if (boundary) begin
               ws_q     <= wsSync;
               bitCnt_q <= '0;
               shreg_q  <= '0;
               case (state_q)
                  HUNT: begin
                     state_q <= (wsSync == WS_RIGHT) ? RIGHT : LEFT;
                  end
                  LEFT: begin
                     hold_q     <= closedExt;
                     haveLeft_q <= 1'b1;
                     short_q    <= isShort;
                     state_q    <= RIGHT;
                  end
                  RIGHT: begin
                     short_q <= isShort;
                     if (haveLeft_q) begin
                        left_q  <= hold_q;
                        right_q <= closedExt;
                        valid_q <= 1'b1;
                     end
                     haveLeft_q <= 1'b0;
                     state_q    <= LEFT;
                  end
                  default: begin
                     state_q <= HUNT;
                  end
               endcase
            end else begin
               shreg_q  <= shreg_d;
               bitCnt_q <= bitCnt_d;
            end
         end
      end
   end

   assign left_data  = left_q;
   assign right_data = right_q;
   assign data_valid = valid_q;
   assign short_word = short_q;

endmodule
